// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: segment encodings, FSM states, decimal helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package calc_pkg;

   // Segment fields are gfedcba with bit0 = a, active high.
   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;

   // Converter sequencing: accept, shift-add-3 for WIDTH cycles, publish.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } fsm_state_e;

   // Width of the elaboration-time decimal arithmetic; covers 10^38 and 2^127.
   localparam int POW_W = 128;

   // 10^n, evaluated at elaboration time.
   function automatic logic [POW_W-1:0] pow10(input int n);
      logic [POW_W-1:0] p;
      p = POW_W'(1);
      for (int i = 0; i < n; i++) begin
         p = p * POW_W'(10);
      end
      return p;
   endfunction

   // Decimal digits needed for any w-bit unsigned value: smallest n with 10^n >= 2^w.
   function automatic int num_dec_digits(input int w);
      int n;
      n = 1;
      while (pow10(n) < (POW_W'(1) << w)) begin
         n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_seg_driver_if.sv
// Value-in / display-out bundle between the ALU result stage and the 7-segment driver.
// Latency: n/a (wiring only).
// Backpressure: producer holds in_value/in_valid until in_ready; display side has no backpressure.
interface bcd_seg_driver_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);

   logic [WIDTH-1:0]      in_value;
   logic                  in_valid;
   logic                  in_ready;
   logic                  out_valid;
   logic                  busy;
   logic                  overflow;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   seg;
   logic [6:0]            seg_sign;

   // Converter side.
   modport slave (
      input  in_value,
      input  in_valid,
      output in_ready,
      output out_valid,
      output busy,
      output overflow,
      output bcd,
      output seg,
      output seg_sign
   );

   // Producer / display consumer side.
   modport master (
      output in_value,
      output in_valid,
      input  in_ready,
      input  out_valid,
      input  busy,
      input  overflow,
      input  bcd,
      input  seg,
      input  seg_sign
   );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to gfedcba segment decoder; codes 10-15 decode to blank.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module bcd_to_seg7
   import calc_pkg::*;
(
   input  logic [3:0]       bcd_dat,
   output logic [SEG_W-1:0] seg_dat
);

   // Table lookup; anything outside 0-9 is left dark rather than showing garbage.
   always_comb begin
      seg_dat = SEG_BLANK;
      unique case (bcd_dat)
         4'd0:    seg_dat = SEG_0;
         4'd1:    seg_dat = SEG_1;
         4'd2:    seg_dat = SEG_2;
         4'd3:    seg_dat = SEG_3;
         4'd4:    seg_dat = SEG_4;
         4'd5:    seg_dat = SEG_5;
         4'd6:    seg_dat = SEG_6;
         4'd7:    seg_dat = SEG_7;
         4'd8:    seg_dat = SEG_8;
         4'd9:    seg_dat = SEG_9;
         default: seg_dat = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_seg_driver.sv
// Signed binary to BCD (double dabble) plus 7-segment encoding; optional LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: accept at cycle N -> out_valid pulse at N+WIDTH+1; next accept at N+WIDTH+2.
// Backpressure: in_ready low from accept until back in IDLE; in_value is ignored meanwhile.
module bcd_seg_driver
   import calc_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bcd_seg_driver_if.slave       io
);

   // The scratch always holds every decimal digit a WIDTH-bit magnitude can have, so
   // digits above the displayed ones act as guard nibbles and nothing is lost.
   localparam int NEED_DIGITS = num_dec_digits(WIDTH);
   localparam int SCR_DIGITS  = (NEED_DIGITS > DIGITS) ? NEED_DIGITS : DIGITS;
   localparam int SCR_W       = 4 * SCR_DIGITS;
   localparam int CNT_W       = $clog2(WIDTH + 1);

   // Largest magnitude that still fits on the display.
   localparam logic [POW_W-1:0] OVF_LIMIT = pow10(DIGITS) - POW_W'(1);

   fsm_state_e              state_q, state_d;
   logic                    sign_q, sign_d;
   logic [WIDTH-1:0]        mag_q, mag_d;
   logic [SCR_W-1:0]        scr_q, scr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_pend_q, ovf_pend_d;

   logic [4*DIGITS-1:0]     bcd_q, bcd_d;
   logic [7*DIGITS-1:0]     seg_q, seg_d;
   logic [SEG_W-1:0]        seg_sign_q, seg_sign_d;
   logic                    overflow_q, overflow_d;

   logic                    in_ready;
   logic                    busy;
   logic                    out_valid;

   logic [WIDTH-1:0]        mag_cap;
   logic                    ovf_cap;
   logic [SCR_W-1:0]        scr_adj;
   logic [SCR_W-1:0]        scr_shift;
   logic [WIDTH-1:0]        mag_shift;
   logic [4*DIGITS-1:0]     bcd_new;
   logic [7*DIGITS-1:0]     seg_new;
   logic [SEG_W-1:0]        dec_seg [DIGITS];

   // Magnitude of the offered value; the most negative input wraps to 2^(WIDTH-1) as unsigned.
   always_comb begin
      mag_cap = io.in_value[WIDTH-1] ? (~io.in_value + WIDTH'(1)) : io.in_value;
      ovf_cap = {{(POW_W-WIDTH){1'b0}}, mag_cap} > OVF_LIMIT;
   end

   // One double-dabble step: add 3 to each nibble >= 5, then shift {scratch, magnitude} left.
   always_comb begin
      scr_adj = scr_q;
      for (int n = 0; n < SCR_DIGITS; n++) begin
         if (scr_q[4*n +: 4] >= 4'd5) begin
            scr_adj[4*n +: 4] = scr_q[4*n +: 4] + 4'd3;
         end
      end
      scr_shift = {scr_adj[SCR_W-2:0], mag_q[WIDTH-1]};
      mag_shift = {mag_q[WIDTH-2:0], 1'b0};
   end

   // Decoders look at the post-shift scratch so the final step's result can be captured directly.
   assign bcd_new = scr_shift[4*DIGITS-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      bcd_to_seg7 u_dec (
         .bcd_dat (scr_shift[4*g +: 4]),
         .seg_dat (dec_seg[g])
      );
   end

   // Display fields: overflow dashes everything, otherwise decoded digits (optionally leading-blanked).
`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic lead;
      seg_new = '0;
      lead    = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (bcd_new[4*i +: 4] != 4'd0) begin
            lead = 1'b0;
         end
         if (ovf_pend_q) begin
            seg_new[7*i +: 7] = SEG_DASH;
         end else if (lead && (i != 0)) begin
            seg_new[7*i +: 7] = SEG_BLANK;
         end else begin
            seg_new[7*i +: 7] = dec_seg[i];
         end
      end
   end
`else
   always_comb begin
      seg_new = '0;
      for (int i = 0; i < DIGITS; i++) begin
         seg_new[7*i +: 7] = ovf_pend_q ? SEG_DASH : dec_seg[i];
      end
   end
`endif

   // Next-state and handshake outputs. Display registers load on the last shift so that
   // they already show the new result during the LOAD cycle, aligned with out_valid.
   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      scr_d       = scr_q;
      cnt_d       = cnt_q;
      ovf_pend_d  = ovf_pend_q;
      bcd_d       = bcd_q;
      seg_d       = seg_q;
      seg_sign_d  = seg_sign_q;
      overflow_d  = overflow_q;
      in_ready    = 1'b0;
      busy        = 1'b0;
      out_valid   = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (io.in_valid) begin
               sign_d     = io.in_value[WIDTH-1];
               mag_d      = mag_cap;
               ovf_pend_d = ovf_cap;
               scr_d      = '0;
               cnt_d      = CNT_W'(WIDTH);
               state_d    = CONV;
            end
         end
         CONV: begin
            busy  = 1'b1;
            scr_d = scr_shift;
            mag_d = mag_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               bcd_d      = bcd_new;
               seg_d      = seg_new;
               seg_sign_d = sign_q ? SEG_DASH : SEG_BLANK;
               overflow_d = ovf_pend_q;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            out_valid = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Converter state; reset abandons any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sign_q     <= 1'b0;
         mag_q      <= '0;
         scr_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         mag_q      <= mag_d;
         scr_q      <= scr_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
      end
   end

   // Display registers; they hold the last result between conversions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q      <= '0;
         seg_q      <= '0;
         seg_sign_q <= SEG_BLANK;
         overflow_q <= 1'b0;
      end else begin
         bcd_q      <= bcd_d;
         seg_q      <= seg_d;
         seg_sign_q <= seg_sign_d;
         overflow_q <= overflow_d;
      end
   end

   assign io.in_ready  = in_ready;
   assign io.busy      = busy;
   assign io.out_valid = out_valid;
   assign io.bcd       = bcd_q;
   assign io.seg       = seg_q;
   assign io.seg_sign  = seg_sign_q;
   assign io.overflow  = overflow_q;

endmodule

// File: doc/bcd_seg_driver.md
Name: bcd_seg_driver

Overview:
Sequential signed-binary to BCD converter and 7-segment encoder that follows the ALU in the calculator datapath. It accepts one signed result per valid/ready handshake and converts it over WIDTH cycles using shift-add-3 (double dabble). It then drives DIGITS digit segment buses plus a sign segment. It replaces the fixed 3-digit combinational display path, adding width/digit parametrisation, negative-number display, overflow indication and a handshake.

Parameters:
WIDTH, 16, bit width of the signed input value (≥2)
DIGITS, 5, number of decimal digits displayed (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_value  in  WIDTH  signed two's-complement value to display
in_valid  in  1  in_value is valid
in_ready  out  1  converter can accept a value
out_valid  out  1  one-cycle pulse; display outputs updated this cycle
busy  out  1  conversion in progress
overflow  out  1  magnitude of last accepted value exceeds 10^DIGITS-1
bcd  out  4*DIGITS  BCD digits of magnitude; digit 0 (ones) in bits [3:0]
seg  out  7*DIGITS  segment bus per digit; digit 0 in bits [6:0]; each field is gfedcba, bit0 = a, active high
seg_sign  out  7  sign position: dash (7'b1000000) if negative, else blank (7'b0000000)

Behaviour:
- Reset (async, rst_n low) and its outputs:
  - State IDLE.
  - in_ready=1, busy=0, out_valid=0, overflow=0.
  - bcd=0, seg all 0 (blank), seg_sign=0.
  - Reset mid-conversion aborts the conversion; no out_valid is issued afterwards.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: capture sign = in_value[WIDTH-1]. Capture magnitude = sign ? -in_value : in_value, in WIDTH-bit unsigned (the most negative value maps to 2^(WIDTH-1) correctly).
    - Clear the BCD scratch, load the bit counter with WIDTH, go to CONV.
  - CONV:
    - busy=1, in_ready=0.
    - Each cycle: add 3 to every scratch nibble ≥5, then shift {scratch, magnitude} left by one.
    - After exactly WIDTH shifts, go to LOAD.
  - LOAD:
    - Register bcd, seg, seg_sign and overflow from scratch/sign.
    - Pulse out_valid for this cycle, return to IDLE.
- Latency: accept at cycle N → out_valid at cycle N+WIDTH+1. Next accept is possible at N+WIDTH+2.
- Throughput: one value per WIDTH+2 cycles.
- in_valid while busy or in LOAD: ignored (in_ready=0); in_value is not sampled.
- Scratch width: 4*DIGITS plus enough guard nibbles to hold ceil(WIDTH*log10(2)) digits, so no bits are lost internally.
- Overflow: set when magnitude > 10^DIGITS-1.
  - All digit seg fields show dash; bcd shows the low DIGITS digits; seg_sign follows sign as normal.
- Zero: sign is never negative for value 0; seg_sign is blank.
- Outputs hold their last value between conversions.
- Digit encodings (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - BCD codes 10–15 encode as blank.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: in LOAD, every digit above the most significant non-zero digit shows blank. Digit 0 always shows, so value 0 shows a single "0". seg_sign moves to no new position; bcd is unaffected.
- Undefined: all DIGITS fields always show their digit, including leading zeros.

Decomposition:
- Package calc_pkg holds:
  - SEG_W=7, SEG_BLANK, SEG_DASH, and the ten digit-encoding constants.
  - An fsm state typedef (IDLE, CONV, LOAD).
  - A constant function pow10(n) used for the overflow threshold and guard-nibble count.
- One sub-module, bcd_to_seg7: combinational 4-bit BCD → 7-bit segment decoder, instantiated DIGITS times via generate.

Test Plan:
- Defaults, in_value=72 (9*8) → out_valid 17 cycles after accept. bcd=0x00072; seg ones=1011011, tens=0000111, upper three=0111111; seg_sign blank; overflow=0.
- in_value=-128 → bcd=0x00128, seg_sign=1000000. in_value=-32768 → bcd=0x32768, overflow=0.
- DIGITS=3, WIDTH=16, in_value=1000 → overflow=1, all three seg fields=1000000, bcd=0x000. Then in_value=999 → overflow=0, bcd=0x999.
- Handshake: hold in_valid high with values 5 then 6 → 5 accepted. in_ready low for 17 cycles, second value ignored until in_ready returns. 6 accepted at cycle N+18.
- Assert rst_n low at the 8th CONV cycle → outputs immediately at reset values, no out_valid pulse. A new conversion after release completes correctly.
- With LEADING_ZERO_BLANK_EN, in_value=0 → digit0=0111111, digits 1–4 blank. in_value=305 → digits 3–4 blank, digit1 (0) shown.
